// File: rtl/tcd1290d_driver.sv
// TCD1290D linear CCD timing generator: SH shift gate, phi1/phi2/phi2B transfer
// clocks and per-pixel RS/CP pulses, all registered in the sys_clk domain.
module tcd1290d_driver #(
    parameter int PIXELS_PER_LINE = 3100,
    parameter int T_SETUP         = 100,
    parameter int SH_PULSE        = 200,
    parameter int T_HOLD          = 100,
    parameter int RS_WIDTH        = 4,
    parameter int CP_DELAY        = 6,
    parameter int CP_WIDTH        = 4,
    parameter int MIN_F1_CNT      = 16
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [19:0] f1_cnt,
    output logic        sh,
    output logic        f1,
    output logic        f2,
    output logic        f2b,
    output logic        rs,
    output logic        cp
);
    localparam int N0    = T_SETUP + SH_PULSE + T_HOLD;
    localparam int WIN_W = $clog2(N0 + 1);

    typedef enum logic [1:0] {
        ST_SETUP   = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    state_t           r_state, w_state_nx;
    logic [WIN_W-1:0] r_win, w_win_nx;
    logic [19:0]      r_phase, w_phase_nx;
    logic [12:0]      r_pix, w_pix_nx;
    logic [19:0]      r_eff;
    logic [19:0]      w_f1_clamped;
    logic             r_sh, r_f1, r_f2, r_f2b, r_rs, r_cp;
    logic             w_sh_nx, w_f1_nx, w_rs_nx, w_cp_nx;

    assign w_f1_clamped = (f1_cnt < 20'(MIN_F1_CNT)) ? 20'(MIN_F1_CNT) : f1_cnt;

    // The counters hold the position n of the current cycle; the output
    // registers are loaded from the position being entered, so they never lag.
    always_comb begin
        w_state_nx = r_state;
        w_win_nx   = r_win;
        w_phase_nx = r_phase;
        w_pix_nx   = r_pix;
        case (r_state)
            ST_SETUP: begin
                w_win_nx = r_win + 1'b1;
                if (r_win == WIN_W'(T_SETUP - 1)) w_state_nx = ST_PULSE;
            end
            ST_PULSE: begin
                w_win_nx = r_win + 1'b1;
                if (r_win == WIN_W'(T_SETUP + SH_PULSE - 1)) w_state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                w_win_nx = r_win + 1'b1;
                if (r_win == WIN_W'(N0 - 1)) begin
                    w_state_nx = ST_READOUT;
                    w_win_nx   = '0;
                    w_phase_nx = '0;
                    w_pix_nx   = '0;
                end
            end
            default: begin
                if (r_phase == r_eff - 20'd1) begin
                    w_phase_nx = '0;
                    if (r_pix == 13'(PIXELS_PER_LINE - 1)) begin
                        w_state_nx = ST_SETUP;
                        w_win_nx   = '0;
                        w_pix_nx   = '0;
                    end else begin
                        w_pix_nx = r_pix + 13'd1;
                    end
                end else begin
                    w_phase_nx = r_phase + 20'd1;
                end
            end
        endcase

        w_sh_nx = (w_state_nx == ST_PULSE);
        w_f1_nx = 1'b1;
        w_rs_nx = 1'b1;
        w_cp_nx = 1'b1;
        if (w_state_nx == ST_READOUT) begin
            w_f1_nx = w_pix_nx[0];
            w_rs_nx = (w_phase_nx < 20'(RS_WIDTH));
            w_cp_nx = (w_phase_nx >= 20'(CP_DELAY)) &&
                      (w_phase_nx < 20'(CP_DELAY + CP_WIDTH));
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_SETUP;
            r_win   <= '0;
            r_phase <= '0;
            r_pix   <= '0;
            r_eff   <= 20'(MIN_F1_CNT);
            r_sh    <= 1'b0;
            r_f1    <= 1'b1;
            r_f2    <= 1'b0;
            r_f2b   <= 1'b0;
            r_rs    <= 1'b1;
            r_cp    <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_win   <= w_win_nx;
            r_phase <= w_phase_nx;
            r_pix   <= w_pix_nx;
            // Pixel period is frozen for the whole line at n=0.
            if (r_state == ST_SETUP && r_win == '0) r_eff <= w_f1_clamped;
            r_sh    <= w_sh_nx;
            r_f1    <= w_f1_nx;
            r_f2    <= ~w_f1_nx;
            r_f2b   <= ~w_f1_nx;
            r_rs    <= w_rs_nx;
            r_cp    <= w_cp_nx;
        end
    end

    assign sh  = r_sh;
    assign f1  = r_f1;
    assign f2  = r_f2;
    assign f2b = r_f2b;
    assign rs  = r_rs;
    assign cp  = r_cp;
endmodule

// File: tb/tb_tcd1290d_driver.sv
// Bench for tcd1290d_driver: per-cycle comparison of all pins against a
// line-position model (n, eff_cnt) under random pixel-period changes and resets.
module tb_tcd1290d_driver;
    localparam int PIX  = 20;
    localparam int TS   = 100;
    localparam int SP   = 200;
    localparam int TH   = 100;
    localparam int N0   = TS + SP + TH;
    localparam int RSW  = 4;
    localparam int CPD  = 6;
    localparam int CPW  = 4;
    localparam int MINC = 16;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [19:0] f1_cnt  = 20'd50;
    logic        sh, f1, f2, f2b, rs, cp;

    int n_checks = 0;
    int n_pass   = 0;
    int n        = 0;
    int line_eff = MINC;

    tcd1290d_driver #(
        .PIXELS_PER_LINE(PIX), .T_SETUP(TS), .SH_PULSE(SP), .T_HOLD(TH),
        .RS_WIDTH(RSW), .CP_DELAY(CPD), .CP_WIDTH(CPW), .MIN_F1_CNT(MINC)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .f1_cnt(f1_cnt),
        .sh(sh), .f1(f1), .f2(f2), .f2b(f2b), .rs(rs), .cp(cp)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s n=%0d eff=%0d got=%0h expected=%0h", tag, n, line_eff, got, exp);
    endtask

    // Pins packed as {sh, f1, f2, f2b, rs, cp}.
    function automatic logic [5:0] expect_pins(input int pos, input int eff);
        logic e_sh, e_f1, e_rs, e_cp;
        int m, k, p;
        e_sh = (pos >= TS) && (pos < TS + SP);
        e_f1 = 1'b1;
        e_rs = 1'b1;
        e_cp = 1'b1;
        if (pos >= N0) begin
            m    = pos - N0;
            k    = m / eff;
            p    = m % eff;
            e_f1 = (k % 2) == 1;
            e_rs = p < RSW;
            e_cp = (p >= CPD) && (p < CPD + CPW);
        end
        return {e_sh, e_f1, ~e_f1, ~e_f1, e_rs, e_cp};
    endfunction

    function automatic int clamp(input logic [19:0] v);
        return (int'(v) < MINC) ? MINC : int'(v);
    endfunction

    // Called at a falling edge with n describing the current cycle.
    task automatic sample_check();
        if (n == 0) line_eff = clamp(f1_cnt);
        check("pins", {26'd0, sh, f1, f2, f2b, rs, cp}, {26'd0, expect_pins(n, line_eff)});
    endtask

    task automatic run(input int cycles);
        repeat (cycles) begin
            n = (n + 1 == N0 + PIX * line_eff) ? 0 : n + 1;
            @(negedge sys_clk);
            sample_check();
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check(tag, {26'd0, sh, f1, f2, f2b, rs, cp}, {26'd0, 6'b010011});
    endtask

    initial begin
        int guard;
        int target;
        #250;
        check_reset_pins("reset_hold");
        check("reset_sh", {31'd0, sh}, 32'd0);
        check("reset_f1", {31'd0, f1}, 32'd1);
        @(negedge sys_clk);
        while ($time < 500) @(negedge sys_clk);
        reset = 1'b0;
        n     = 0;
        sample_check();

        // First full line plus half of the next, then retune mid-readout.
        run(N0 + PIX * 50 + N0 + 7 * 50);
        f1_cnt = 20'd80;
        run(2 * (N0 + PIX * 80));
        f1_cnt = 20'd3;
        run(2 * (N0 + PIX * 80));

        for (int i = 0; i < 24; i++) begin
            f1_cnt = 20'($urandom_range(0, 60));
            run($urandom_range(50, 1500));
        end
        f1_cnt = 20'(MINC);
        run(N0 + PIX * 70);
        f1_cnt = 20'd50;

        // Reach pixel 13 of a readout, then reset between clock edges.
        guard = 0;
        target = N0 + 13 * line_eff + 5;
        while (n != target && guard < 5000) begin
            run(1);
            guard++;
            target = N0 + 13 * line_eff + 5;
        end
        check("reach_pixel13", {31'd0, n == target}, 32'd1);
        #3 reset = 1'b1;
        #1 check_reset_pins("async_reset");
        @(negedge sys_clk);
        check_reset_pins("reset_held_edge");
        @(negedge sys_clk);
        reset = 1'b0;
        n     = 0;
        sample_check();
        run(2 * (N0 + PIX * 50) + 30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout n=%0d", n);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "bench time limit");
    end
endmodule
